// File: rtl/mul32u_seq_pkg.sv
// Shared state encodings and widths for the 32x32 unsigned sequential multiplier.
package mul32u_seq_pkg;

   localparam int OP_W   = 32;
   localparam int PROD_W = 64;
   localparam int CNT_W  = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mul32u_seq_add64.sv
// 64-bit combinational adder; the single adder shared by every multiply step.
module mul32u_seq_add64
   import mul32u_seq_pkg::*;
(
   input  logic [PROD_W-1:0] a_i,
   input  logic [PROD_W-1:0] b_i,
   output logic [PROD_W-1:0] sum_o
);

   assign sum_o = a_i + b_i;

endmodule

// File: rtl/mul32u_seq.sv
// Shift-and-add 32x32 unsigned multiplier, one partial product per RUN cycle.
// Define MUL32U_SEQ_EARLY_EXIT_EN to stop as soon as no multiplier bits remain.
module mul32u_seq
   import mul32u_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [OP_W-1:0]   mcand,
   input  logic [OP_W-1:0]   mplier,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] prod
);

   state_e              state_q,  state_d;
   logic [PROD_W-1:0]   mcand_q,  mcand_d;
   logic [OP_W-1:0]     mplier_q, mplier_d;
   logic [PROD_W-1:0]   acc_q,    acc_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [PROD_W-1:0]   prod_q,   prod_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;
   logic [PROD_W-1:0]   addend_s;
   logic [PROD_W-1:0]   sum_s;
   logic                last_s;

   assign addend_s = mplier_q[0] ? mcand_q : {PROD_W{1'b0}};

   mul32u_seq_add64 u_add (
      .a_i   (acc_q),
      .b_i   (addend_s),
      .sum_o (sum_s)
   );

   // Final step: the 32nd iteration, or earlier once the shifted multiplier is empty.
   always_comb begin
      last_s = (cnt_q == 6'd31);
`ifdef MUL32U_SEQ_EARLY_EXIT_EN
      if (mplier_q[OP_W-1:1] == 31'd0) begin
         last_s = 1'b1;
      end else begin
         last_s = (cnt_q == 6'd31);
      end
`endif
   end

   // Next-state, datapath step and registered output values.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_RUN;
               mcand_d  = {32'd0, mcand};
               mplier_d = mplier;
               acc_d    = {PROD_W{1'b0}};
               cnt_d    = {CNT_W{1'b0}};
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d    = sum_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 6'd1;
            if (last_s) begin
               state_d = ST_DONE;
               prod_d  = sum_s;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         mcand_q  <= {PROD_W{1'b0}};
         mplier_q <= {OP_W{1'b0}};
         acc_q    <= {PROD_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         prod_q   <= {PROD_W{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign prod = prod_q;

endmodule

// File: tb/tb_mul32u_seq.sv
// Directed scoreboard bench for mul32u_seq; honours MUL32U_SEQ_EARLY_EXIT_EN for latency.
module tb_mul32u_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic        busy;
   logic        done;
   logic [63:0] prod;

   int          checks;
   int          errors;
   logic [63:0] exp_q[$];

   mul32u_seq dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .mcand  (mcand),
      .mplier (mplier),
      .busy   (busy),
      .done   (done),
      .prod   (prod)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [31:0] b);
      int h;
      h = 0;
`ifdef MUL32U_SEQ_EARLY_EXIT_EN
      for (int i = 0; i < 32; i++) begin
         if (b[i]) h = i;
      end
      return h + 1;
`else
      return 32 + h;
`endif
   endfunction

   // Drive one accepted start; inputs are scrambled right after acceptance.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      exp_q.push_back({32'd0, a} * {32'd0, b});
      @(posedge clk);
      #1;
      start  = 1'b0;
      mcand  = $urandom;
      mplier = $urandom;
   endtask

   // Wait for done, counting busy cycles, then score the product.
   task automatic wait_done(input int exp_cycles, input string tag);
      int          n;
      int          i;
      bit          seen;
      logic [63:0] e;
      n    = 0;
      i    = 0;
      seen = 1'b0;
      while (i < 40 && !seen) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) n++;
         i++;
      end
      check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
      if (seen) begin
         check({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
         check({tag, "_busy_low_at_done"}, {63'd0, busy}, 64'd0);
         check({tag, "_sb_nonempty"}, {63'd0, (exp_q.size() != 0)}, 64'd1);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'd0;
         check({tag, "_prod"}, prod, e);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      mcand  = 32'd0;
      mplier = 32'd0;
      #3;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_prod", prod, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Test 1: 3*5, latency and done falling the cycle after.
      issue(32'd3, 32'd5);
      wait_done(exp_lat(32'd5), "t1");
      check("t1_prod_const", prod, 64'h000000000000000F);
      @(negedge clk);
      check("t1_done_falls", {63'd0, done}, 64'd0);
      check("t1_idle_busy", {63'd0, busy}, 64'd0);
      check("t1_prod_held", prod, 64'h000000000000000F);

      // Test 2: maximum operands.
      @(negedge clk);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(exp_lat(32'hFFFFFFFF), "t2");
      check("t2_prod_const", prod, 64'hFFFFFFFE00000001);

      // Test 3: early-exit boundary operands (full latency in the default build).
      @(negedge clk);
      issue(32'd12345, 32'd0);
      wait_done(exp_lat(32'd0), "t3_zero");
      @(negedge clk);
      issue(32'd7, 32'd1);
      wait_done(exp_lat(32'd1), "t3_one");
      @(negedge clk);
      issue(32'd2, 32'h80000000);
      wait_done(exp_lat(32'h80000000), "t3_msb");
      check("t3_msb_const", prod, 64'h0000000100000000);

      // Test 4: start and input changes during RUN are ignored; back-to-back in DONE.
      @(negedge clk);
      issue(32'd6, 32'd7);
      @(negedge clk);
      check("t4_busy_mid", {63'd0, busy}, 64'd1);
      start  = 1'b1;
      mcand  = 32'd9;
      mplier = 32'd9;
      @(negedge clk);
      start  = 1'b0;
      mcand  = 32'hDEADBEEF;
      mplier = 32'h12345678;
      wait_done(exp_lat(32'd7) - 2, "t4_first");
      check("t4_prod_42", prod, 64'd42);
      issue(32'd9, 32'd9);
      wait_done(exp_lat(32'd9), "t4_b2b");
      check("t4_prod_81", prod, 64'd81);

      // Test 5: reset in the middle of RUN.
      @(negedge clk);
      issue(32'hABCD1234, 32'hFFFF0001);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", {63'd0, busy}, 64'd0);
      check("t5_rst_done", {63'd0, done}, 64'd0);
      check("t5_rst_prod", prod, 64'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("t5_no_done", {63'd0, done}, 64'd0);
      rst_n = 1'b1;
      issue(32'd4, 32'd4);
      wait_done(exp_lat(32'd4), "t5_after");
      check("t5_prod_16", prod, 64'd16);

      // A few random operand pairs.
      for (int r = 0; r < 4; r++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom;
         b = $urandom;
         @(negedge clk);
         issue(a, b);
         wait_done(exp_lat(b), "rand");
      end

      @(negedge clk);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      check("final_done_low", {63'd0, done}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul32u_seq.md
MUL32U_SEQ -- requirements
Module: mul32u_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 mcand  input  32  unsigned multiplicand; sampled with an accepted start.
REQ-006 mplier  input  32  unsigned multiplier; sampled with an accepted start.
REQ-007 busy  output  1  high while a multiplication is in progress.
REQ-008 done  output  1  single-cycle pulse; prod is valid.
REQ-009 prod  output  64  unsigned product; held until the next accepted start.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-011 In IDLE or DONE, start=1 at edge k SHALL be accepted.
- On acceptance: latch mcand zero-extended to 64 bits, latch mplier, clear the accumulator and the 6-bit iteration counter, enter RUN.
REQ-012 Each RUN cycle SHALL perform one step:
- If mplier_r[0]=1: acc <= acc + mcand_r, as a 64-bit add that cannot overflow.
- Then mcand_r <= mcand_r << 1, mplier_r <= mplier_r >> 1, counter +1.
REQ-013 Without early exit, RUN SHALL last exactly 32 cycles.
- busy=1 in the cycles following edges k..k+31.
- At edge k+32: state becomes DONE, busy=0, done=1, prod=acc.
REQ-014 DONE SHALL last one cycle. Without a start it returns to IDLE and done falls to 0 at edge k+33.
REQ-015 start=1 in DONE SHALL be accepted (back-to-back), so done is high for one cycle only.
REQ-016 start during RUN SHALL be ignored; input changes during RUN SHALL NOT affect the result.
REQ-017 prod SHALL equal mcand*mplier exactly for all 2^64 operand pairs and SHALL change only at transition into DONE.

Reset
REQ-018 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, prod=0, and clear all internal registers, including mid-RUN; an aborted operation produces no done.
REQ-019 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-020 Macro MUL32U_SEQ_EARLY_EXIT_EN SHALL select early termination.
- Defined: RUN ends at the edge where the post-shift mplier_r becomes 0 (and at the latest after 32 steps). Latency = (index of the highest set bit of mplier)+1 cycles; mplier=0 takes 1 RUN cycle.
- Undefined: fixed 32-cycle latency per REQ-013.
- The product SHALL be identical in both builds.

Structure
REQ-021 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the operand/product widths SHALL be defined in a shared header in IPs_shared, included with guard macros.
REQ-022 The 64-bit addition SHALL be one instantiated combinational sub-module Add64, placed in IPs_shared alongside Sub64.
REQ-023 The block SHALL be purely iterative (one adder), not an unrolled array.

Verification
REQ-024 Test 1, basic product and latency: mcand=3, mplier=5, start at edge k (early exit off).
- prod=64'h000000000000000F.
- done=1 only after edge k+32.
- busy high for exactly 32 cycles.
REQ-025 Test 2, maximum operands: mcand=mplier=32'hFFFFFFFF.
- prod=64'hFFFFFFFE00000001.
REQ-026 Test 3, early-exit latency (MUL32U_SEQ_EARLY_EXIT_EN defined).
- mplier=0: 1 RUN cycle, prod=0.
- mplier=1, mcand=7: 1 RUN cycle, prod=7.
- mplier=32'h80000000, mcand=2: 32 RUN cycles, prod=64'h100000000.
REQ-027 Test 4, start during RUN: issue 6*7, then pulse start with 9*9 and change the inputs mid-RUN.
- prod=42; one done only.
- Start again in the DONE cycle with 9*9: prod=81 after 32 further cycles.
REQ-028 Test 5, reset mid-run: drop rst_n at RUN cycle 10.
- busy, done and prod go to 0 immediately, with no done.
- After release, 4*4 yields prod=16.
